// File: rtl/cpu0_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for cpu0: TXDATA/STATUS registers, TX FIFO and serializer.
// Optional transmit-done interrupt (and STATUS.ie) is built only when CPU0_UART_IRQ_EN is defined.
module cpu0_uart_tx #(
  parameter logic [31:0] IOADDR = 32'h7000,
  parameter int          DIV    = 16,
  parameter int          DEPTH  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        rw,
  input  logic [1:0]  m_size,
  input  logic [31:0] abus,
  input  logic [31:0] dbus_in,
  output logic [31:0] dbus_out,
  output logic        txd,
  output logic        irq
);
  localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [15:0]     BIT_LOAD   = 16'(DIV - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     timer_q, timer_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            en_prev_q, en_prev_d;
  logic [7:0]      fifo_mem [DEPTH];

  logic            sel_tx, sel_st, wr_acc, push, pop, next_frame;
  logic            empty, full, busy, ie;
  logic [4:0]      count_wide;
  logic [31:0]     status;
  logic            unused_bits;

  assign sel_tx = (abus == IOADDR);
  assign sel_st = (abus == IOADDR + 32'd4);
  // cpu0 holds en for several clocks; only the rising edge of en is a new access.
  assign wr_acc = en & ~en_prev_q & ~rw & ~reset;
  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_COUNT);
  assign busy   = (state_q != IDLE);
  assign push   = wr_acc & sel_tx & ~full;
  assign next_frame = ~empty & ((state_q == IDLE) | ((state_q == STOP) & (timer_q == '0)));

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= dbus_in[7:0];
    end
  end

  always_comb begin
    en_prev_d = en;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ovf_d     = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    if (wr_acc && sel_tx && full) ovf_d = 1'b1;
    if (wr_acc && sel_st)         ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        if (timer_q == '0) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
          timer_d = BIT_LOAD;
          state_d = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          timer_d = BIT_LOAD;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          txd_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Starting a frame (from IDLE or straight out of STOP) pops the head and drops txd at once.
    if (next_frame) begin
      pop     = 1'b1;
      shift_d = fifo_mem[rd_ptr_q];
      txd_d   = 1'b0;
      bit_d   = '0;
      timer_d = BIT_LOAD;
      state_d = START;
    end
  end

  always_ff @(posedge clock) begin
    en_prev_q <= en_prev_d;
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef CPU0_UART_IRQ_EN
  logic ie_q, ie_d, irq_q, irq_d;

  always_comb begin
    ie_d = ie_q;
    if (wr_acc && sel_st) ie_d = dbus_in[7];
    irq_d = ie_q & empty & ~busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  // STATUS count field is 4 bits wide; a full 16-entry FIFO reads count 0 with full=1.
  assign count_wide = 5'(count_q);

  always_comb begin
    status      = '0;
    status[0]   = busy;
    status[1]   = full;
    status[2]   = empty;
    status[6:3] = count_wide[3:0];
    status[7]   = ie;
    status[8]   = ovf_q;
  end

  assign dbus_out = (en && rw && sel_st) ? status :
                    ((en && rw && sel_tx) ? 32'h0 : 32'bz);
  assign txd = txd_q;

  assign unused_bits = ^{m_size, dbus_in[31:8], count_wide[4]};
endmodule

// File: tb/tb_cpu0_uart_tx.sv
// Directed bench for cpu0_uart_tx (DIV=4, DEPTH=4): register table plus frame, overflow, reset and irq sequences.
`timescale 1ns/1ps
module tb_cpu0_uart_tx;
  localparam int          DIV    = 4;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] TXADDR = 32'h7000;
  localparam logic [31:0] STADDR = 32'h7004;
`ifdef CPU0_UART_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  typedef struct {
    int          kind;   // 0 write, 1 read value, 2 read expecting Z, 3 en low expecting Z
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, en, rw;
  logic [1:0]  m_size;
  logic [31:0] abus, dbus_in;
  wire  [31:0] dbus_out;
  logic        txd, irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] rx_byte[$];
  int         rx_start[$];
  logic       rx_stop[$];

  cpu0_uart_tx #(.IOADDR(32'h7000), .DIV(DIV), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .en(en), .rw(rw), .m_size(m_size),
    .abus(abus), .dbus_in(dbus_in), .dbus_out(dbus_out), .txd(txd), .irq(irq)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial receiver: samples each bit in its middle and logs byte, start cycle and stop bit.
  initial begin : monitor
    logic [7:0] b;
    int st;
    b = '0;
    forever begin
      @(posedge clock); #2;
      if (txd === 1'b0) begin
        st = cyc;
        repeat (DIV/2) @(posedge clock);
        for (int k = 0; k < 8; k++) begin
          repeat (DIV) @(posedge clock); #2;
          b[k] = txd;
        end
        repeat (DIV) @(posedge clock); #2;
        rx_byte.push_back(b);
        rx_start.push_back(st);
        rx_stop.push_back(txd);
        repeat (DIV/2 - 1) @(posedge clock);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input int hold);
    @(negedge clock);
    en = 1'b1; rw = 1'b0; abus = a; dbus_in = d;
    repeat (hold) @(posedge clock);
    #1;
    en = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    en = 1'b1; rw = 1'b1; abus = a;
    #1;
    d = dbus_out;
    #1;
    en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    s = 32'h1;
    while (s[0] && n < 400) begin
      @(posedge clock); #1;
      bus_read(STADDR, s);
      n++;
    end
    total++;
    if (s[0]) begin
      bad++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, s[0], n);
    end
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic clear_rx();
    rx_byte.delete();
    rx_start.delete();
    rx_stop.delete();
  endtask

  initial begin
    vec_t vt[13];
    logic [31:0] s;
    logic [9:0]  pat;
    int nz;

    vt[0]  = '{1, STADDR,        32'h0,        32'h4,                  "st_idle"};
    vt[1]  = '{1, TXADDR,        32'h0,        32'h0,                  "txdata_read"};
    vt[2]  = '{2, 32'h7008,      32'h0,        32'h0,                  "z_7008"};
    vt[3]  = '{2, 32'h7005,      32'h0,        32'h0,                  "z_7005"};
    vt[4]  = '{3, STADDR,        32'h0,        32'h0,                  "z_en_low"};
    vt[5]  = '{0, STADDR,        32'h80,       32'h0,                  "wr_ie1"};
    vt[6]  = '{1, STADDR,        32'h0,        IRQ_ON ? 32'h84 : 32'h4, "st_ie_set"};
    vt[7]  = '{0, STADDR,        32'hFFFFFF7F, 32'h0,                  "wr_ie0"};
    vt[8]  = '{1, STADDR,        32'h0,        32'h4,                  "st_ie_clr"};
    vt[9]  = '{0, STADDR,        32'h80,       32'h0,                  "wr_ie1b"};
    vt[10] = '{1, STADDR,        32'h0,        IRQ_ON ? 32'h84 : 32'h4, "st_ie_again"};
    vt[11] = '{0, STADDR,        32'h0,        32'h0,                  "wr_ie0b"};
    vt[12] = '{1, STADDR,        32'h0,        32'h4,                  "st_final"};

    reset = 1'b1; en = 1'b0; rw = 1'b1; m_size = 2'b10; abus = '0; dbus_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    bus_read(STADDR, s);
    chk("rst_status", s, 32'h4);
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;

    // Register access table
    for (int i = 0; i < 13; i++) begin
      case (vt[i].kind)
        0: begin
          bus_write(vt[i].addr, vt[i].wdata, 1);
          @(posedge clock); #1;
        end
        1: begin
          bus_read(vt[i].addr, s);
          chk(vt[i].name, s, vt[i].exp);
          @(posedge clock); #1;
        end
        default: begin
          en = (vt[i].kind == 2); rw = 1'b1; abus = vt[i].addr;
          #1;
          total++;
          if (dbus_out !== 32'hzzzz_zzzz) begin
            bad++;
            $display("FAIL %s: dbus_out=%h, required zzzzzzzz", vt[i].name, dbus_out);
          end
          en = 1'b0;
          @(posedge clock); #1;
        end
      endcase
    end

    // Single frame of 8'h55
    clear_rx();
    bus_write(TXADDR, 32'h55, 1);
    chk("A_txd_at_accept", 32'(txd), 32'd1);
    bus_read(STADDR, s);
    chk("A_status_at_accept", s, 32'h8);
    @(posedge clock); #1;
    pat = 10'b10_1010_1010;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < DIV; c++) begin
        if (k != 0 || c != 0) begin
          @(posedge clock); #1;
        end
        chk($sformatf("A_txd_c%0d", k*DIV + c), 32'(txd), 32'(pat[k]));
      end
    end
    bus_read(STADDR, s);
    chk("A_status_last_stop_clk", s, 32'h5);
    @(posedge clock); #1;
    bus_read(STADDR, s);
    chk("A_status_after_frame", s, 32'h4);
    chk("A_txd_idle", 32'(txd), 32'd1);
    repeat (4) @(posedge clock); #1;
    chk("A_rx_count", 32'(rx_byte.size()), 32'd1);
    if (rx_byte.size() >= 1) chk("A_rx_byte", 32'(rx_byte[0]), 32'h55);

    // en held for 3 clocks: exactly one accept
    clear_rx();
    bus_write(TXADDR, 32'hA5, 3);
    bus_read(STADDR, s);
    chk("B_status_after_hold", s, 32'h5);
    wait_idle("B_idle");
    chk("B_rx_count", 32'(rx_byte.size()), 32'd1);
    if (rx_byte.size() >= 1) chk("B_rx_byte", 32'(rx_byte[0]), 32'hA5);

    // Six rapid writes: five back-to-back frames, sixth dropped with overflow
    clear_rx();
    for (int k = 1; k <= 6; k++) begin
      bus_write(TXADDR, 32'(k), 1);
      if (k < 6) @(posedge clock);
    end
    bus_read(STADDR, s);
    chk("C_status_overflow", s, 32'h123);
    @(posedge clock); #1;
    bus_write(STADDR, 32'h0, 1);
    bus_read(STADDR, s);
    chk("C_status_ovf_cleared", s, 32'h23);
    wait_idle("C_idle");
    chk("C_rx_count", 32'(rx_byte.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_byte.size()) begin
        chk($sformatf("C_rx_byte%0d", i), 32'(rx_byte[i]), 32'(i + 1));
        chk($sformatf("C_rx_stop%0d", i), 32'(rx_stop[i]), 32'd1);
        if (i > 0) chk($sformatf("C_gap%0d", i), 32'(rx_start[i] - rx_start[i-1]), 32'(10*DIV));
      end
    end

    // Reset at clock 12 of a frame, with a bus write in the reset cycle
    bus_write(TXADDR, 32'h00, 1);
    @(posedge clock);
    bus_write(TXADDR, 32'h00, 1);
    repeat (9) @(posedge clock);
    #1;
    chk("D_txd_mid_frame", 32'(txd), 32'd0);
    @(negedge clock);
    reset = 1'b1; en = 1'b1; rw = 1'b0; abus = TXADDR; dbus_in = 32'h33;
    @(posedge clock); #1;
    chk("D_txd_after_reset", 32'(txd), 32'd1);
    @(negedge clock);
    reset = 1'b0; en = 1'b0; rw = 1'b1;
    @(posedge clock); #1;
    bus_read(STADDR, s);
    chk("D_status_after_reset", s, 32'h4);
    nz = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (txd !== 1'b1) nz++;
    end
    chk("D_txd_low_cycles", 32'(nz), 32'd0);
    clear_rx();

    // Transmit-done interrupt
    bus_write(STADDR, 32'h80, 1);
    @(posedge clock);
    bus_write(TXADDR, 32'h00, 1);
    @(posedge clock); #1;
    chk("E_txd_fall", 32'(txd), 32'd0);
    nz = 0;
    for (int i = 0; i <= 10*DIV; i++) begin
      if (i > 0) begin
        @(posedge clock); #1;
      end
      if (irq !== 1'b0) nz++;
    end
    chk("E_irq_high_in_frame", 32'(nz), 32'd0);
    @(posedge clock); #1;
    chk("E_irq_after_frame", 32'(irq), IRQ_ON);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
